// File: rtl/fwd_pkg.sv
// Shared types for the forwarding scoreboard: in-flight entry layout, regfile select code, select width helper.
// No logic and no latency of its own.
package fwd_pkg;

  localparam int unsigned FWD_REGFILE    = 0;
  // Entries carry a fixed-width rd; narrower register indices are zero-extended.
  localparam int unsigned REG_ADDR_W_MAX = 8;

  typedef logic [REG_ADDR_W_MAX-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      is_load;
  } entry_t;

  function automatic int unsigned sel_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Youngest-match priority encoder for one source port against the forwardable in-flight entries.
// Purely combinational; no flow control.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_ENT = 2,
  parameter int unsigned SEL_W   = 2
) (
  input  logic                      used,
  input  reg_addr_t                 rs,
  input  entry_t [NUM_ENT-1:0]      ent,
  output logic                      hit,
  output logic [SEL_W-1:0]          sel,
  output logic                      is_load
);

  // Scan oldest to youngest so the lowest index is the last, winning, assignment.
  always_comb begin
    hit     = 1'b0;
    sel     = SEL_W'(FWD_REGFILE);
    is_load = 1'b0;
    for (int j = int'(NUM_ENT) - 1; j >= 0; j--) begin
      if (used && (rs != '0) && ent[j].valid && (ent[j].rd == rs)) begin
        hit     = 1'b1;
        sel     = SEL_W'(j + 1);
        is_load = ent[j].is_load;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand bypass select and load-use stall, decided in ID and registered into EX (1 cycle); ext_stall freezes all state.
// Optional FWD_STORE_DATA_EN: store data from a just-issued load is bypassed WB->MEM instead of stalling.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned REG_ADDR_W   = 6,
  parameter int unsigned DEPTH        = 3,
  parameter int unsigned LOAD_STAGE   = 2
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   ext_stall,
  input  logic                                   flush,
  input  logic                                   id_valid,
  input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0]     id_rs,
  input  logic [NUM_RD_PORTS-1:0]                id_rs_used,
  input  logic [REG_ADDR_W-1:0]                  id_rd,
  input  logic                                   id_rd_we,
  input  logic                                   id_is_load,
  input  logic                                   id_is_store,
  output logic [NUM_RD_PORTS*sel_w(DEPTH)-1:0]   ex_fwd_sel,
  output logic                                   ld_use_stall,
  output logic                                   mem_fwd_store
);

  localparam int unsigned SEL_W   = sel_w(DEPTH);
  // The WB entry is never a forward source, so only EX..DEPTH-2 are stored.
  localparam int unsigned NUM_ENT = DEPTH - 1;

  entry_t [NUM_ENT-1:0]                    ent_q;
  entry_t                                  id_ent;
  logic   [NUM_RD_PORTS-1:0]               hit;
  logic   [NUM_RD_PORTS-1:0]               is_ld;
  logic   [NUM_RD_PORTS-1:0]               stall_p;
  logic   [NUM_RD_PORTS-1:0][SEL_W-1:0]    sel;
  logic   [NUM_RD_PORTS*SEL_W-1:0]         dec;
  logic                                    raw_stall;
  logic                                    bubble;

  assign id_ent = '{valid:   id_valid & id_rd_we & (id_rd != '0),
                    rd:      REG_ADDR_W_MAX'(id_rd),
                    is_load: id_is_load};

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    fwd_match #(.NUM_ENT(NUM_ENT), .SEL_W(SEL_W)) u_match (
      .used    (id_rs_used[p]),
      .rs      (REG_ADDR_W_MAX'(id_rs[p*REG_ADDR_W +: REG_ADDR_W])),
      .ent     (ent_q),
      .hit     (hit[p]),
      .sel     (sel[p]),
      .is_load (is_ld[p])
    );
    // Load data is not ready yet when the consumer reaches EX.
    assign stall_p[p] = hit[p] & is_ld[p] & (sel[p] < SEL_W'(LOAD_STAGE));
  end

`ifdef FWD_STORE_DATA_EN
  logic st_fwd;
  logic st_ex_q;
  logic st_mem_q;

  always_comb begin
    st_fwd    = id_is_store & stall_p[1] & (sel[1] == SEL_W'(LOAD_STAGE - 1))
              & ~|(stall_p & ~NUM_RD_PORTS'(2));
    raw_stall = |stall_p & ~st_fwd;
    dec       = sel;
    if (st_fwd) dec[SEL_W +: SEL_W] = '0;
  end

  // Flag rides with the store; a store has no valid entry of its own.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_ex_q  <= 1'b0;
      st_mem_q <= 1'b0;
    end else if (!ext_stall) begin
      st_ex_q  <= st_fwd & ~bubble;
      st_mem_q <= st_ex_q;
    end
  end

  assign mem_fwd_store = st_mem_q;
`else
  logic unused_store;

  assign unused_store  = id_is_store;
  assign mem_fwd_store = 1'b0;

  always_comb begin
    raw_stall = |stall_p;
    dec       = sel;
  end
`endif

  assign ld_use_stall = raw_stall & id_valid & ~flush;
  assign bubble       = ld_use_stall | flush | ~id_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ent_q      <= '0;
      ex_fwd_sel <= '0;
    end else if (!ext_stall) begin
      ent_q[0] <= bubble ? '0 : id_ent;
      for (int i = 1; i < int'(NUM_ENT); i++) ent_q[i] <= ent_q[i-1];
      ex_fwd_sel <= bubble ? '0 : dec;
    end
  end

endmodule
